// File: rtl/bp_pkg.sv
// Shared constants and helpers for the set-associative branch predictor.
package bp_pkg;

  localparam logic [1:0] CORR_NONE = 2'b00;
  localparam logic [1:0] CORR_CNI  = 2'b10;
  localparam logic [1:0] CORR_PBT  = 2'b11;

  // exe_btype is {beq, bne, blt, bge, bltu, bgeu}
  localparam int BT_BEQ  = 5;
  localparam int BT_BNE  = 4;
  localparam int BT_BLT  = 3;
  localparam int BT_BGE  = 2;
  localparam int BT_BLTU = 1;
  localparam int BT_BGEU = 0;

  // Entry layout, MSB first: {valid, tag, target, counter}
  function automatic int entry_w(
    input int pc_w,
    input int set_w,
    input int cnt_w
  );
    return 1 + (pc_w - set_w) + pc_w + cnt_w;
  endfunction

  function automatic logic [31:0] cnt_sat(
    input logic [31:0] cnt,
    input logic        up,
    input int          w
  );
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    if (up) return (cnt == top) ? cnt : cnt + 32'd1;
    else    return (cnt == '0)  ? cnt : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/bht_set_lookup.sv
// Tag compare across the ways of one set; muxes out the hit entry.
module bht_set_lookup
  import bp_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int TAG_W = 6,
  parameter int WAYS  = 4,
  parameter int WAY_W = 2,
  parameter int CNT_W = 2
) (
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAYS-1:0][TAG_W-1:0] tags_i,
  input  logic [WAYS-1:0][PC_W-1:0]  tgts_i,
  input  logic [WAYS-1:0][CNT_W-1:0] cnts_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       hit_o,
  output logic [WAY_W-1:0]           way_o,
  output logic [PC_W-1:0]            tgt_o,
  output logic [CNT_W-1:0]           cnt_o
);

  logic [WAYS-1:0] hit_oh;

  always_comb begin
    hit_oh = '0;
    way_o  = '0;
    tgt_o  = '0;
    cnt_o  = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_oh[w] = valid_i[w] && (tags_i[w] == tag_i);
      if (hit_oh[w]) begin
        way_o = WAY_W'(w);
        tgt_o = tgts_i[w];
        cnt_o = cnts_i[w];
      end
    end
  end

  assign hit_o = |hit_oh;

endmodule

// File: rtl/bht_sa_predictor.sv
// Set-associative BHT: IF prediction, ID allocation, EXE resolution.
module bht_sa_predictor
  import bp_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int SETS  = 16,
  parameter int WAYS  = 4,
  parameter int CNT_W = 2
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [PC_W-1:0] if_PC,
  output logic            if_prediction,
  output logic [PC_W-1:0] if_PBT,
  input  logic [PC_W-1:0] id_PC,
  input  logic [PC_W-1:0] id_branchtarget,
  input  logic            id_is_jump,
  input  logic            id_is_btype,
  input  logic [PC_W-1:0] exe_PC,
  input  logic [PC_W-1:0] exe_branchtarget,
  input  logic            exe_z,
  input  logic            exe_less,
  input  logic [5:0]      exe_btype,
  output logic [1:0]      exe_correction,
  output logic            flush,
  output logic [PC_W-1:0] exe_PBT,
  output logic [PC_W-1:0] exe_CNI
);

  localparam int SET_W   = $clog2(SETS);
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W   = PC_W - SET_W;
  localparam int ENTRY_W = entry_w(PC_W, SET_W, CNT_W);
  localparam int TGT_LO  = CNT_W;
  localparam int TAG_LO  = CNT_W + PC_W;

  localparam logic [CNT_W-1:0] CNT_WNT =
    CNT_W'((1 << (CNT_W - 1)) - 1);

  typedef logic [SETS-1:0][WAYS-1:0][ENTRY_W-1:0] tbl_t;

  tbl_t                        tbl_q, tbl_d;
  logic [SETS-1:0][WAY_W-1:0]  rr_q, rr_d;

  logic [PC_W-1:0]  pc_a   [3];
  logic             lu_hit [3];
  logic [WAY_W-1:0] lu_way [3];
  logic [PC_W-1:0]  lu_tgt [3];
  logic [CNT_W-1:0] lu_cnt [3];

  assign pc_a[0] = if_PC;
  assign pc_a[1] = id_PC;
  assign pc_a[2] = exe_PC;

  for (genvar p = 0; p < 3; p++) begin : g_lu
    logic [SET_W-1:0]           set;
    logic [WAYS-1:0]            v;
    logic [WAYS-1:0][TAG_W-1:0] tg;
    logic [WAYS-1:0][PC_W-1:0]  tt;
    logic [WAYS-1:0][CNT_W-1:0] ct;

    assign set = pc_a[p][SET_W-1:0];

    always_comb begin
      v  = '0;
      tg = '0;
      tt = '0;
      ct = '0;
      for (int w = 0; w < WAYS; w++) begin
        v[w]  = tbl_q[set][w][ENTRY_W-1];
        tg[w] = tbl_q[set][w][TAG_LO +: TAG_W];
        tt[w] = tbl_q[set][w][TGT_LO +: PC_W];
        ct[w] = tbl_q[set][w][0 +: CNT_W];
      end
    end

    bht_set_lookup #(
      .PC_W  (PC_W),
      .TAG_W (TAG_W),
      .WAYS  (WAYS),
      .WAY_W (WAY_W),
      .CNT_W (CNT_W)
    ) u_lookup (
      .valid_i (v),
      .tags_i  (tg),
      .tgts_i  (tt),
      .cnts_i  (ct),
      .tag_i   (pc_a[p][PC_W-1:SET_W]),
      .hit_o   (lu_hit[p]),
      .way_o   (lu_way[p]),
      .tgt_o   (lu_tgt[p]),
      .cnt_o   (lu_cnt[p])
    );
  end

  assign if_prediction = lu_cnt[0][CNT_W-1];
  assign if_PBT        = lu_tgt[0];

  logic is_br;
  logic fb;
  logic pred;

  assign is_br = |exe_btype;
  assign pred  = lu_cnt[2][CNT_W-1];
  assign fb    = (exe_btype[BT_BEQ]  &  exe_z)
               | (exe_btype[BT_BNE]  & ~exe_z)
               | (exe_btype[BT_BLT]  &  exe_less)
               | (exe_btype[BT_BGE]  & ~exe_less)
               | (exe_btype[BT_BLTU] &  exe_less)
               | (exe_btype[BT_BGEU] & ~exe_less);

  always_comb begin
    exe_correction = CORR_NONE;
    if (is_br && (pred != fb))
      exe_correction = fb ? CORR_PBT : CORR_CNI;
  end

  assign flush   = exe_correction[1];
  assign exe_PBT = exe_branchtarget;
  assign exe_CNI = exe_PC + 1'b1;

  logic [SET_W-1:0] id_set;
  logic [SET_W-1:0] ex_set;
  logic             id_alloc;

  assign id_set   = id_PC[SET_W-1:0];
  assign ex_set   = exe_PC[SET_W-1:0];
  assign id_alloc = (id_is_btype | id_is_jump) & ~lu_hit[1];

  // ID write is applied last so it overrides an EXE update to the same way
  always_comb begin
    tbl_d = tbl_q;
    rr_d  = rr_q;
    if (is_br && lu_hit[2])
      tbl_d[ex_set][lu_way[2]][0 +: CNT_W] =
        CNT_W'(cnt_sat(32'(lu_cnt[2]), fb, CNT_W));
    if (id_alloc) begin
      tbl_d[id_set][rr_q[id_set]] = {
        1'b1,
        id_PC[PC_W-1:SET_W],
        id_branchtarget,
        id_is_jump ? {CNT_W{1'b1}} : CNT_WNT
      };
      rr_d[id_set] = (rr_q[id_set] == WAY_W'(WAYS - 1))
                   ? '0 : rr_q[id_set] + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      tbl_q <= '0;
      rr_q  <= '0;
    end else begin
      tbl_q <= tbl_d;
      rr_q  <= rr_d;
    end
  end

endmodule

// File: doc/bht_sa_predictor.md
# bht_sa_predictor

Parametrised set-associative branch history table and predictor for the pipelined core, generalising the fixed 64-entry, 4-way, 10-bit-PC predictor. It supplies a taken/not-taken prediction and a predicted target to IF and allocates branch and jump entries from ID. It resolves branches in EXE and drives the next-PC correction and flush. Geometry, PC width and counter width are parameters.

## Interface
- PC_W, 10: PC width in words; all PC and target ports are word addresses.
- SETS, 16: number of sets; power of two, at least 2. SET_W = log2(SETS).
- WAYS, 4: ways per set; power of two, at least 1. WAY_W = max(1, log2(WAYS)).
- CNT_W, 2: saturating counter width, at least 1. The prediction is the counter MSB.
- CLK, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- if_PC, input, PC_W: fetch PC for lookup.
- if_prediction, output, 1: counter MSB of the hit entry; 0 on miss.
- if_PBT, output, PC_W: target of the hit entry; 0 on miss.
- id_PC, input, PC_W: decode-stage PC.
- id_branchtarget, input, PC_W: target computed in ID.
- id_is_jump, input, 1: ID holds a jump.
- id_is_btype, input, 1: ID holds a conditional branch. Mutually exclusive with id_is_jump.
- exe_PC, input, PC_W: execute-stage PC.
- exe_branchtarget, input, PC_W: resolved target of the branch in EXE.
- exe_z, input, 1: ALU zero flag.
- exe_less, input, 1: ALU less-than flag.
- exe_btype, input, 6: one-hot branch type {beq, bne, blt, bge, bltu, bgeu}; all zeros means no branch.
- exe_correction, output, 2: 00 means no correction, 10 means select exe_CNI, 11 means select exe_PBT.
- flush, output, 1: equals exe_correction[1].
- exe_PBT, output, PC_W: equals exe_branchtarget.
- exe_CNI, output, PC_W: exe_PC + 1, modulo 2^PC_W.

## Operation
- Entry fields:
  - valid, 1 bit.
  - tag, PC_W−SET_W bits, taken from PC[PC_W−1:SET_W].
  - target, PC_W bits.
  - counter, CNT_W bits.
- Set index is PC[SET_W−1:0]. A hit requires valid and an equal tag. At most one way per set can hit, because allocation only occurs on a miss.
- Lookup runs in parallel at three ports (IF, ID, EXE). Each port is a combinational read of registered state.
- ID allocation:
  - Condition: (id_is_btype | id_is_jump) and the ID lookup misses.
  - The entry is written to way rr_ptr[set] with valid=1, tag, target = id_branchtarget.
  - Initial counter: jump gives all-ones; btype gives 2^(CNT_W−1)−1 (weakly not-taken; 0 when CNT_W=1).
  - rr_ptr[set] then increments, wrapping WAYS−1 to 0.
  - On an ID hit, no write occurs and the pointer is unchanged.
- EXE resolution:
  - feedback = beq&z | bne&!z | blt&less | bge&!less | bltu&less | bgeu&!less.
  - pred = counter MSB of the EXE hit entry, or 0 on miss.
  - If exe_btype==0: exe_correction=00 and there is no update.
  - Else if pred==feedback: 00.
  - Else if feedback==0: 10.
  - Else: 11.
- EXE counter update:
  - Applies when exe_btype≠0 and the EXE lookup hits.
  - feedback=1 increments the counter, saturating at all-ones.
  - feedback=0 decrements the counter, saturating at 0.
  - Only the counter field is written.
  - An EXE miss produces no update and no allocation.
- Simultaneous ID allocation and EXE update:
  - Different entries: both writes commit.
  - Same set and way: the ID allocation wins and the EXE update is dropped.
- Reset clears every valid bit, every counter and every rr_ptr to 0. Targets and tags need no reset.

## Timing
- The IF, ID and EXE outputs are combinational from the inputs and the registered table, with zero latency.
- Writes commit at the rising edge. They are visible to lookups from the next cycle. There is no same-cycle write-to-read bypass.
- Reset values while rst=1 (all valid bits clear):
  - if_prediction=0, if_PBT=0.
  - exe_correction=00 if exe_btype=0. Otherwise exe_correction=11 iff feedback=1, else 00.
  - flush follows exe_correction[1].
- Reset asserted mid-operation takes effect immediately. Any write in that cycle is lost.
- A set that allocates WAYS+1 distinct PCs evicts the oldest entry, in FIFO order.

## Structure
- Package bp_pkg holds:
  - Correction codes CORR_NONE=2'b00, CORR_CNI=2'b10, CORR_PBT=2'b11.
  - exe_btype bit indices.
  - An entry-width function of (PC_W, SET_W, CNT_W).
- Sub-module bht_set_lookup (tag compare, one-hot hit, way select, hit flag) is instantiated three times, once each for IF, ID and EXE.
- Counter saturate logic is a function in bp_pkg.

## Test plan
- Reset, then if_PC=0x024 → if_prediction=0, if_PBT=0. With exe_btype=beq and exe_z=1: exe_correction=11 and flush=1.
- ID btype at PC 0x024 with target 0x100, then a next-cycle IF at 0x024 → hit, if_PBT=0x100, if_prediction=0 (counter 01).
- EXE beq at 0x024 taken twice → counter goes 01, 10, 11, with corrections 11 then 00. Taken a third time → counter stays 11. Then not taken → correction 10, exe_CNI=0x025, counter 10.
- Five btypes with distinct tags, all in set 4 → the fifth replaces the first; the first PC now misses at IF and the other four hit.
- ID allocation into set 4 way 0 while EXE updates the entry it evicts, in the same cycle → the table holds the new entry with its initial counter.
- ID jump at an already-present PC → no write, rr_ptr unchanged. Jump allocation at a new PC → counter 11 and if_prediction=1.
